// File: rtl/logger_arbiter_if.sv
// Debug-source and logger-side signals of the logger arbiter.
// The arbiter takes the slave view; sources and logger drive the master view.
interface logger_arbiter_if #(
    parameter int SRC_WIDTH = 34
);
    logic [3:0]             src_valid;
    logic [4*SRC_WIDTH-1:0] src_data;
    logic                   dump_done;
    logic                   log_wr_en;
    logic [SRC_WIDTH+1:0]   log_data;
    logic                   log_rd_start;

    modport slave (
        input  src_valid,
        input  src_data,
        input  dump_done,
        output log_wr_en,
        output log_data,
        output log_rd_start
    );

    modport master (
        output src_valid,
        output src_data,
        output dump_done,
        input  log_wr_en,
        input  log_data,
        input  log_rd_start
    );
endinterface

// File: rtl/logger_arbiter.sv
// Shares one diagnostic logger between four debug sources (round-robin, 2-bit source tag)
// and sequences a capture: arm, trigger, post-trigger write count, dump, wait for dump done.
module logger_arbiter #(
    parameter int SRC_WIDTH = 34,
    parameter int CNT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm_i,
    input  logic                 trigger_i,
    input  logic [CNT_WIDTH-1:0] post_count_i,
    output logic [1:0]           state_o,
    output logic [7:0]           drop_cnt_o,
    logger_arbiter_if.slave      dbg_bus
);

    // state | meaning
    // IDLE  | waiting for arm, sources ignored
    // ARMED | capturing, waiting for a trigger rising edge
    // POST  | capturing, counting writes up to the latched post_count
    // DUMP  | rd_start issued on entry, writes blocked until dump_done
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DUMP  = 2'd3
    } state_t;

    state_t                 state_q;
    logic                   trig_q;
    logic [CNT_WIDTH-1:0]   post_len_q;
    logic [CNT_WIDTH-1:0]   post_cnt_q;
    logic                   rd_start_q;
    logic [1:0]             ptr_q;
    logic [3:0]             full_q;
    logic [SRC_WIDTH-1:0]   hold_q [4];
    logic                   wr_en_q;
    logic [SRC_WIDTH+1:0]   data_q;
    logic [7:0]             drop_q;

    logic                   cap_en;
    logic                   trig_edge;
    logic [CNT_WIDTH-1:0]   post_cnt_inc;
    logic                   enter_dump;
    logic                   gnt_vld;
    logic                   grant_ok;
    logic [1:0]             gnt_idx;
    logic [1:0]             cand;
    logic [3:0]             drop_vec;
    logic [2:0]             drop_num;
    logic [8:0]             drop_sum;
    logic [7:0]             drop_d;

    assign cap_en       = (state_q == S_ARMED) || (state_q == S_POST);
    assign trig_edge    = trigger_i & ~trig_q;
    assign post_cnt_inc = post_cnt_q + CNT_WIDTH'(1);
    assign enter_dump   = ((state_q == S_ARMED) && trig_edge && (post_len_q == '0)) ||
                          ((state_q == S_POST) && wr_en_q && (post_cnt_inc == post_len_q));

    // The search walks down from offset 3 so the last hit is the one nearest the pointer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (full_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // No grant on the edge into DUMP: the winner would be discarded by the register clear anyway.
    assign grant_ok = gnt_vld & cap_en & ~enter_dump;

    always_comb begin
        drop_vec = '0;
        drop_num = '0;
        for (int i = 0; i < 4; i++) begin
            drop_vec[i] = cap_en & dbg_bus.src_valid[i] & full_q[i] &
                          ~(grant_ok & (gnt_idx == 2'(i)));
            drop_num    = drop_num + {2'b00, drop_vec[i]};
        end
        drop_sum = {1'b0, drop_q} + {6'b0, drop_num};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            trig_q     <= 1'b0;
            post_len_q <= '0;
            post_cnt_q <= '0;
            rd_start_q <= 1'b0;
        end else begin
            trig_q     <= trigger_i;
            rd_start_q <= enter_dump;
            case (state_q)
                S_IDLE: begin
                    if (arm_i) begin
                        state_q    <= S_ARMED;
                        post_len_q <= post_count_i;
                        post_cnt_q <= '0;
                    end
                end
                S_ARMED: begin
                    if (trig_edge) begin
                        state_q <= (post_len_q == '0) ? S_DUMP : S_POST;
                    end
                end
                S_POST: begin
                    if (wr_en_q) begin
                        post_cnt_q <= post_cnt_inc;
                        if (post_cnt_inc == post_len_q) begin
                            state_q <= S_DUMP;
                        end
                    end
                end
                S_DUMP: begin
                    if (dbg_bus.dump_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            full_q  <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            drop_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            wr_en_q <= 1'b0;
            if ((state_q == S_IDLE) && arm_i) begin
                drop_q <= '0;
            end else if (|drop_vec) begin
                drop_q <= drop_d;
            end
            if (enter_dump || (state_q == S_DUMP)) begin
                full_q <= '0;
            end else begin
                if (grant_ok) begin
                    wr_en_q         <= 1'b1;
                    data_q          <= {gnt_idx, hold_q[gnt_idx]};
                    ptr_q           <= gnt_idx + 2'd1;
                    full_q[gnt_idx] <= 1'b0;
                end
                for (int i = 0; i < 4; i++) begin
                    if (cap_en && dbg_bus.src_valid[i] && !drop_vec[i]) begin
                        full_q[i] <= 1'b1;
                        hold_q[i] <= dbg_bus.src_data[i*SRC_WIDTH +: SRC_WIDTH];
                    end
                end
            end
        end
    end

    assign state_o              = state_q;
    assign drop_cnt_o           = drop_q;
    assign dbg_bus.log_wr_en    = wr_en_q;
    assign dbg_bus.log_data     = data_q;
    assign dbg_bus.log_rd_start = rd_start_q;

endmodule

// File: tb/tb_logger_arbiter.sv
// Directed bench for logger_arbiter: stimulus pushes expected log writes and dump starts,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_logger_arbiter;
    localparam int SW = 34;
    localparam int CW = 12;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          arm;
    logic          trigger;
    logic [CW-1:0] post_count;
    logic [1:0]    state;
    logic [7:0]    drop_cnt;

    logger_arbiter_if #(.SRC_WIDTH(SW)) bus ();

    logger_arbiter #(.SRC_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm_i       (arm),
        .trigger_i   (trigger),
        .post_count_i(post_count),
        .state_o     (state),
        .drop_cnt_o  (drop_cnt),
        .dbg_bus     (bus)
    );

    typedef struct {
        logic [SW+1:0] data;
        int            cyc;
    } exp_t;

    exp_t wq[$];
    int   rq[$];
    exp_t mon_e;
    int   mon_r;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   c;
    logic [SW-1:0] sp [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.log_wr_en) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got data=%h at cyc=%0d, none expected", bus.log_data, cyc);
                end else begin
                    mon_e = wq.pop_front();
                    if (bus.log_data !== mon_e.data || cyc != mon_e.cyc) begin
                        failures++;
                        $display("FAIL log_write got data=%h cyc=%0d want data=%h cyc=%0d",
                                 bus.log_data, cyc, mon_e.data, mon_e.cyc);
                    end
                end
            end
            if (bus.log_rd_start) begin
                checks++;
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rd_start at cyc=%0d, none expected", cyc);
                end else begin
                    mon_r = rq.pop_front();
                    if (cyc != mon_r) begin
                        failures++;
                        $display("FAIL rd_start got cyc=%0d want cyc=%0d", cyc, mon_r);
                    end
                end
            end
            if (state == 2'd3) begin
                checks++;
                if (bus.log_wr_en !== 1'b0) begin
                    failures++;
                    $display("FAIL wr_in_dump got wr_en=%b want 0 at cyc=%0d", bus.log_wr_en, cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_w(input logic [1:0] id, input logic [SW-1:0] p, input int cy);
        exp_t e;
        e.data = {id, p};
        e.cyc  = cy;
        wq.push_back(e);
    endtask

    task automatic set_src(input logic [3:0] m, input logic [SW-1:0] p0, input logic [SW-1:0] p1,
                           input logic [SW-1:0] p2, input logic [SW-1:0] p3);
        bus.src_valid = m;
        bus.src_data  = {p3, p2, p1, p0};
    endtask

    task automatic do_arm(input logic [CW-1:0] n);
        post_count = n;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
        post_count = '0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        arm = 1'b0; trigger = 1'b0; post_count = '0;
        bus.src_valid = '0; bus.src_data = '0; bus.dump_done = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_wr_en", 64'(bus.log_wr_en), 64'd0);
        chk("rst_rd_start", 64'(bus.log_rd_start), 64'd0);
        chk("rst_data", 64'(bus.log_data), 64'd0);

        // strobes in IDLE are neither logged nor counted
        tick();
        set_src(4'b1111, 34'h1, 34'h2, 34'h3, 34'h4);
        tick();
        set_src(4'b1111, 34'h1, 34'h2, 34'h3, 34'h4);
        tick();
        bus.src_valid = '0;
        ticks(4);
        chk("idle_drop", 64'(drop_cnt), 64'd0);
        chk("idle_state", 64'(state), 64'd0);

        do_arm(12'd3);
        chk("armed_state", 64'(state), 64'd1);

        c = cyc;
        set_src(4'b0001, 34'h1, '0, '0, '0);
        push_w(2'd0, 34'h1, c + 2);
        tick();
        bus.src_valid = '0;
        ticks(4);

        c = cyc;
        set_src(4'b1000, '0, '0, '0, 34'h3_0000_00AB);
        push_w(2'd3, 34'h3_0000_00AB, c + 2);
        tick();
        bus.src_valid = '0;
        ticks(4);

        // two round-robin bursts, pointer back at 0 before each
        for (int b = 0; b < 2; b++) begin
            c = cyc;
            set_src(4'b1111, 34'h0_1111_0000 + 34'(b), 34'h1_2222_0000 + 34'(b),
                    34'h2_3333_0000 + 34'(b), 34'h3_4444_0000 + 34'(b));
            push_w(2'd0, 34'h0_1111_0000 + 34'(b), c + 2);
            push_w(2'd1, 34'h1_2222_0000 + 34'(b), c + 3);
            push_w(2'd2, 34'h2_3333_0000 + 34'(b), c + 4);
            push_w(2'd3, 34'h3_4444_0000 + 34'(b), c + 5);
            tick();
            bus.src_valid = '0;
            ticks(6);
        end

        // src2 strobes twice while src0/src1 are ahead of it: second strobe lost
        c = cyc;
        set_src(4'b0111, 34'h0_D000_0000, 34'h1_D000_0001, 34'h2_D000_002A, '0);
        push_w(2'd0, 34'h0_D000_0000, c + 2);
        push_w(2'd1, 34'h1_D000_0001, c + 3);
        push_w(2'd2, 34'h2_D000_002A, c + 4);
        tick();
        set_src(4'b0100, '0, '0, 34'h2_D000_002B, '0);
        tick();
        bus.src_valid = '0;
        ticks(4);
        chk("drop_one", 64'(drop_cnt), 64'd1);

        // back-to-back on a source granted that cycle reloads without a drop
        c = cyc;
        set_src(4'b1000, '0, '0, '0, 34'h3_E000_000A);
        push_w(2'd3, 34'h3_E000_000A, c + 2);
        push_w(2'd3, 34'h3_E000_000B, c + 3);
        tick();
        set_src(4'b1000, '0, '0, '0, 34'h3_E000_000B);
        tick();
        bus.src_valid = '0;
        ticks(4);
        chk("drop_granted_reload", 64'(drop_cnt), 64'd1);

        // 90 cycles of all-source strobes: 3 drops per contended cycle, saturating at 255
        sp[0] = 34'h0_5A5A_0000; sp[1] = 34'h1_5A5A_0001;
        sp[2] = 34'h2_5A5A_0002; sp[3] = 34'h3_5A5A_0003;
        c = cyc;
        for (int k = 0; k < 93; k++) push_w(2'(k % 4), sp[k % 4], c + 2 + k);
        set_src(4'b1111, sp[0], sp[1], sp[2], sp[3]);
        ticks(90);
        bus.src_valid = '0;
        ticks(8);
        chk("drop_saturated", 64'(drop_cnt), 64'd255);

        // arm and dump_done outside their states are ignored
        bus.dump_done = 1'b1;
        arm           = 1'b1;
        post_count    = 12'd1;
        tick();
        bus.dump_done = 1'b0;
        arm           = 1'b0;
        post_count    = '0;
        tick();
        chk("ignored_events_state", 64'(state), 64'd1);

        // capture with the latched post_count of 3; pointer sits at 1
        c = cyc;
        trigger = 1'b1;
        set_src(4'b1110, '0, 34'h1_F000_0001, 34'h2_F000_0002, 34'h3_F000_0003);
        push_w(2'd1, 34'h1_F000_0001, c + 2);
        push_w(2'd2, 34'h2_F000_0002, c + 3);
        push_w(2'd3, 34'h3_F000_0003, c + 4);
        rq.push_back(c + 5);
        tick();
        bus.src_valid = '0;
        chk("post_state", 64'(state), 64'd2);
        ticks(4);
        chk("dump_state", 64'(state), 64'd3);
        trigger = 1'b0;
        ticks(2);
        chk("dump_hold_state", 64'(state), 64'd3);
        bus.dump_done = 1'b1;
        tick();
        bus.dump_done = 1'b0;
        chk("dump_done_idle", 64'(state), 64'd0);

        // post_count=5 with 8 strobes available; dump_done coincides with rd_start
        do_arm(12'd5);
        chk("rearm_state", 64'(state), 64'd1);
        chk("arm_clears_drop", 64'(drop_cnt), 64'd0);
        c = cyc;
        trigger = 1'b1;
        set_src(4'b1111, 34'h0_6000_0000, 34'h1_6000_0001, 34'h2_6000_0002, 34'h3_6000_0003);
        push_w(2'd0, 34'h0_6000_0000, c + 2);
        push_w(2'd1, 34'h1_6000_0001, c + 3);
        push_w(2'd2, 34'h2_6000_0002, c + 4);
        push_w(2'd3, 34'h3_6000_0003, c + 5);
        push_w(2'd0, 34'h0_7000_0000, c + 6);
        rq.push_back(c + 7);
        tick();
        bus.src_valid = '0;
        chk("post5_state", 64'(state), 64'd2);
        ticks(3);
        set_src(4'b1111, 34'h0_7000_0000, 34'h1_7000_0001, 34'h2_7000_0002, 34'h3_7000_0003);
        tick();
        bus.src_valid = '0;
        ticks(2);
        chk("post5_dump_state", 64'(state), 64'd3);
        bus.dump_done = 1'b1;
        tick();
        bus.dump_done = 1'b0;
        trigger       = 1'b0;
        chk("coincident_done_idle", 64'(state), 64'd0);
        chk("post5_drop", 64'(drop_cnt), 64'd0);

        // reset mid-POST, right while a write is on the bus
        do_arm(12'd5);
        c = cyc;
        trigger = 1'b1;
        set_src(4'b0001, 34'h0_ABCD_EF01, '0, '0, '0);
        push_w(2'd0, 34'h0_ABCD_EF01, c + 2);
        tick();
        bus.src_valid = '0;
        tick();
        @(negedge clk);
        #1 chk("pre_reset_wr_en", 64'(bus.log_wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 64'(state), 64'd0);
        chk("async_rst_wr_en", 64'(bus.log_wr_en), 64'd0);
        chk("async_rst_data", 64'(bus.log_data), 64'd0);
        chk("async_rst_rd_start", 64'(bus.log_rd_start), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        trigger = 1'b0;
        ticks(12);
        chk("after_reset_state", 64'(state), 64'd0);

        // trigger already high at arm gives no edge; a later edge with post_count=0 dumps at once
        trigger = 1'b1;
        ticks(2);
        do_arm(12'd0);
        chk("held_trig_armed", 64'(state), 64'd1);
        ticks(8);
        chk("held_trig_stays_armed", 64'(state), 64'd1);
        trigger = 1'b0;
        tick();
        c = cyc;
        trigger = 1'b1;
        rq.push_back(c + 1);
        tick();
        chk("zero_post_dump_state", 64'(state), 64'd3);
        chk("zero_post_no_write", 64'(bus.log_wr_en), 64'd0);
        ticks(2);
        bus.dump_done = 1'b1;
        tick();
        bus.dump_done = 1'b0;
        trigger       = 1'b0;
        chk("zero_post_idle", 64'(state), 64'd0);

        ticks(5);
        chk("writes_outstanding", 64'(wq.size()), 64'd0);
        chk("rd_starts_outstanding", 64'(rq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
